// File: rtl/trigger_pkg.sv
// Shared command codes and state encodings for the ROC control responder.
// Latency: n/a (package only).
// Backpressure: n/a.
package trigger_pkg;

    // Command patterns as they sit in the shift register once the
    // terminating 00 has been shifted in (start bit at position len-1).
    localparam logic [6:0] TRG_CODE = 7'b0000100;
    localparam logic [2:0] TRG_LEN  = 3'd3;
    localparam logic [6:0] CAL_CODE = 7'b0010100;
    localparam logic [2:0] CAL_LEN  = 3'd5;
    localparam logic [6:0] RSR_CODE = 7'b0101100;
    localparam logic [2:0] RSR_LEN  = 3'd6;

    // Longest run of bits accepted before a command is declared malformed.
    localparam logic [2:0] CMD_MAX_LEN = 3'd7;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} dec_state_t;

    typedef enum logic [1:0] {T_IDLE, T_WAIT, T_OUT} tok_state_t;

endpackage

// File: rtl/ctr_decoder.sv
// Serial roc_ctr command decoder: TRG/CAL/RSR recognition and malformed detection.
// Latency: strobes are high for the clk cycle after the sync edge sampling the final 0; *_hit are same-edge.
// Backpressure: none; one bit is consumed on every sync edge.
module ctr_decoder
    import trigger_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sync,
    input  logic ctr,
    output logic trg_hit,
    output logic rsr_hit,
    output logic cmd_trg,
    output logic cmd_cal,
    output logic cmd_rsr,
    output logic cmd_err
);

    dec_state_t state, state_nx;
    logic [6:0] sr, sr_nx, sr_sh;
    logic [2:0] cnt, cnt_nx, cnt_sh;
    logic       zero_seen, zero_seen_nx;
    logic       cal_hit, err_hit;

    // State, shift register and registered one-clk strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            zero_seen <= 1'b0;
            cmd_trg   <= 1'b0;
            cmd_cal   <= 1'b0;
            cmd_rsr   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            cnt       <= cnt_nx;
            zero_seen <= zero_seen_nx;
            cmd_trg   <= trg_hit;
            cmd_cal   <= cal_hit;
            cmd_rsr   <= rsr_hit;
            cmd_err   <= err_hit;
        end
    end

    // Next-state and classification; hits are only ever raised on sync edges.
    always_comb begin
        state_nx     = state;
        sr_nx        = sr;
        cnt_nx       = cnt;
        zero_seen_nx = zero_seen;
        sr_sh        = {sr[5:0], ctr};
        cnt_sh       = cnt + 3'd1;
        trg_hit      = 1'b0;
        cal_hit      = 1'b0;
        rsr_hit      = 1'b0;
        err_hit      = 1'b0;
        if (sync) begin
            case (state)
                IDLE: begin
                    if (ctr) begin
                        state_nx = SHIFT;
                        sr_nx    = 7'd1;
                        cnt_nx   = 3'd1;
                    end
                end
                SHIFT: begin
                    sr_nx  = sr_sh;
                    cnt_nx = cnt_sh;
                    if (sr_sh[1:0] == 2'b00) begin
                        state_nx = IDLE;
                        if (cnt_sh == TRG_LEN && sr_sh == TRG_CODE) begin
                            trg_hit = 1'b1;
                        end else if (cnt_sh == CAL_LEN && sr_sh == CAL_CODE) begin
                            cal_hit = 1'b1;
                        end else if (cnt_sh == RSR_LEN && sr_sh == RSR_CODE) begin
                            rsr_hit = 1'b1;
                        end else begin
                            err_hit = 1'b1;
                        end
                    end else if (cnt_sh == CMD_MAX_LEN) begin
                        // Too long without a terminator: report once, then
                        // swallow the rest of the line noise until 00.
                        err_hit      = 1'b1;
                        state_nx     = FLUSH;
                        zero_seen_nx = 1'b0;
                    end
                end
                FLUSH: begin
                    if (!ctr) begin
                        if (zero_seen) begin
                            state_nx = IDLE;
                        end
                        zero_seen_nx = 1'b1;
                    end else begin
                        zero_seen_nx = 1'b0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/roc_ctr_responder.sv
// Single-ROC emulator: decodes roc_ctr, tracks pending triggers, answers tin with a delayed tout.
// Latency: strobes/pending one clk after the deciding sync edge; tout rises TOKEN_DELAY sync periods after tin.
// Backpressure: none; a tin arriving while a token is in flight is dropped and flagged on tin_err.
module roc_ctr_responder
    import trigger_pkg::*;
#(
    parameter int TOKEN_DELAY = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              ctr,
    input  logic              tin,
    output logic              tout,
    output logic              cmd_trg,
    output logic              cmd_cal,
    output logic              cmd_rsr,
    output logic              cmd_err,
    output logic              tin_err,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        DLY_LOAD = 8'(TOKEN_DELAY - 1);

    logic       trg_hit, rsr_hit;
    tok_state_t tok, tok_nx;
    logic [7:0] dcnt, dcnt_nx;
    logic       tok_accept, tin_err_nx, pend_dec;

    ctr_decoder u_dec (
        .clk     (clk),
        .reset   (reset),
        .sync    (sync),
        .ctr     (ctr),
        .trg_hit (trg_hit),
        .rsr_hit (rsr_hit),
        .cmd_trg (cmd_trg),
        .cmd_cal (cmd_cal),
        .cmd_rsr (cmd_rsr),
        .cmd_err (cmd_err)
    );

    assign tout     = (tok == T_OUT);
    assign pend_dec = tok_accept && (pending != '0);

    // Token state register, delay counter and tin_err strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tok     <= T_IDLE;
            dcnt    <= '0;
            tin_err <= 1'b0;
        end else begin
            tok     <= tok_nx;
            dcnt    <= dcnt_nx;
            tin_err <= tin_err_nx;
        end
    end

    // Token sequencing; RSR aborts whatever is in flight and wins over tin.
    always_comb begin
        tok_nx     = tok;
        dcnt_nx    = dcnt;
        tok_accept = 1'b0;
        tin_err_nx = 1'b0;
        if (sync) begin
            if (rsr_hit) begin
                tok_nx = T_IDLE;
            end else begin
                case (tok)
                    T_IDLE: begin
                        if (tin) begin
                            tok_nx     = T_WAIT;
                            dcnt_nx    = DLY_LOAD;
                            tok_accept = 1'b1;
                        end
                    end
                    T_WAIT: begin
                        tin_err_nx = tin;
                        if (dcnt == 8'd0) begin
                            tok_nx = T_OUT;
                        end else begin
                            dcnt_nx = dcnt - 8'd1;
                        end
                    end
                    T_OUT: begin
                        tin_err_nx = tin;
                        tok_nx     = T_IDLE;
                    end
                    default: tok_nx = T_IDLE;
                endcase
            end
        end
    end

    // Pending-trigger counter: saturating up on TRG, down on issued token, cleared by RSR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (sync) begin
            if (rsr_hit) begin
                pending  <= '0;
                overflow <= 1'b0;
            end else begin
                if (trg_hit && pending == PEND_MAX) begin
                    overflow <= 1'b1;
                end
                if (trg_hit && !pend_dec && pending != PEND_MAX) begin
                    pending <= pending + 1'b1;
                end else if (pend_dec && !trg_hit) begin
                    pending <= pending - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_roc_ctr_responder.sv
// Self-checking bench for roc_ctr_responder with a command/token reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_roc_ctr_responder;

    localparam int D      = 8;
    localparam int PW     = 4;
    localparam int PMAX   = 15;
    localparam int SYNC_T = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sync = 1'b0;
    logic          ctr = 1'b0;
    logic          tin = 1'b0;
    logic          tout, cmd_trg, cmd_cal, cmd_rsr, cmd_err, tin_err, overflow;
    logic [PW-1:0] pending;

    int total = 0;
    int bad   = 0;

    roc_ctr_responder #(.TOKEN_DELAY(D), .PEND_W(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .sync     (sync),
        .ctr      (ctr),
        .tin      (tin),
        .tout     (tout),
        .cmd_trg  (cmd_trg),
        .cmd_cal  (cmd_cal),
        .cmd_rsr  (cmd_rsr),
        .cmd_err  (cmd_err),
        .tin_err  (tin_err),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit  q[$];
    int  mode = 0;            // 0 idle, 1 collecting, 2 flushing
    int  fz = 0;
    int  sidx = 0;
    int  tok_s = 0;
    bit  tok_act = 0;
    int  m_pend = 0;
    bit  m_ovf = 0, m_tout = 0;
    bit  m_trg = 0, m_cal = 0, m_rsr = 0, m_err = 0, m_terr = 0;
    time t_acc = 0;
    int  n, v;
    bit  acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            mode = 0; fz = 0; tok_act = 0; m_pend = 0; m_ovf = 0; m_tout = 0;
            m_trg = 0; m_cal = 0; m_rsr = 0; m_err = 0; m_terr = 0;
        end else begin
            m_trg = 0; m_cal = 0; m_rsr = 0; m_err = 0; m_terr = 0;
            if (sync) begin
                sidx++;
                // command recognition on the bit list collected since the start bit
                if (mode == 0) begin
                    if (ctr) begin
                        q.delete();
                        q.push_back(1'b1);
                        mode = 1;
                    end
                end else if (mode == 1) begin
                    q.push_back(ctr);
                    n = q.size();
                    if (q[n-1] == 1'b0 && q[n-2] == 1'b0) begin
                        v = 0;
                        foreach (q[i]) v = v * 2 + int'(q[i]);
                        if (n == 3 && v == 4)       m_trg = 1;
                        else if (n == 5 && v == 20) m_cal = 1;
                        else if (n == 6 && v == 44) m_rsr = 1;
                        else                        m_err = 1;
                        mode = 0;
                    end else if (n == 7) begin
                        m_err = 1;
                        mode = 2;
                        fz = 0;
                    end
                end else begin
                    if (!ctr) begin
                        fz++;
                        if (fz == 2) mode = 0;
                    end else begin
                        fz = 0;
                    end
                end
                // token and pending bookkeeping
                acc = 0;
                if (m_rsr) begin
                    tok_act = 0;
                    m_pend = 0;
                    m_ovf = 0;
                end else begin
                    if (tin) begin
                        if (tok_act) begin
                            m_terr = 1;
                        end else begin
                            acc = 1;
                            tok_act = 1;
                            tok_s = sidx;
                            t_acc = $time;
                        end
                    end
                    if (m_trg && m_pend == PMAX) m_ovf = 1;
                    if (m_trg && !(acc && m_pend > 0)) begin
                        if (m_pend < PMAX) m_pend++;
                    end else if (acc && m_pend > 0 && !m_trg) begin
                        m_pend--;
                    end
                end
                m_tout = tok_act && (sidx == tok_s + D);
                if (tok_act && sidx >= tok_s + D + 1) tok_act = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    int  n_trg = 0, n_cal = 0, n_rsr = 0, n_err = 0, n_terr = 0, n_rise = 0, n_hi = 0;
    bit  tout_q = 0;
    time t_rise = 0;

    always @(posedge clk) begin
        #2;
        check("cmd_trg", cmd_trg, m_trg);
        check("cmd_cal", cmd_cal, m_cal);
        check("cmd_rsr", cmd_rsr, m_rsr);
        check("cmd_err", cmd_err, m_err);
        check("tin_err", tin_err, m_terr);
        check("tout", tout, m_tout);
        check("pending", pending, m_pend);
        check("overflow", overflow, m_ovf);
        if (cmd_trg) n_trg++;
        if (cmd_cal) n_cal++;
        if (cmd_rsr) n_rsr++;
        if (cmd_err) n_err++;
        if (tin_err) n_terr++;
        if (tout) n_hi++;
        if (tout && !tout_q) begin
            n_rise++;
            t_rise = $time - 2;
        end
        tout_q = tout;
    end

    // ---------------- stimulus ----------------
    task automatic sp(input bit c, input bit t);
        @(negedge clk);
        sync = 1'b1;
        ctr  = c;
        tin  = t;
        @(negedge clk);
        sync = 1'b0;
        tin  = 1'b0;
    endtask

    task automatic send(input int code, input int len);
        for (int i = len - 1; i >= 0; i--) sp(((code >> i) & 1) != 0, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) sp(1'b0, 1'b0);
    endtask

    int b_trg, b_cal, b_rsr, b_err, b_terr, b_rise, b_hi;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tout", tout, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cmd_trg", cmd_trg, 0);
        reset = 1'b1;
        idle(2);

        // TRG
        b_trg = n_trg;
        send(4, 3);
        idle(1);
        check("trg_count", n_trg - b_trg, 1);
        check("trg_pending", pending, 1);

        // CAL, then two more TRGs and RSR
        b_cal = n_cal;
        send(20, 5);
        idle(1);
        check("cal_count", n_cal - b_cal, 1);
        send(4, 3);
        send(4, 3);
        check("pend_three", pending, 3);
        b_rsr = n_rsr;
        send(44, 6);
        idle(1);
        check("rsr_count", n_rsr - b_rsr, 1);
        check("rsr_pending", pending, 0);

        // Malformed: seven ones then 00, then a clean TRG
        b_err = n_err;
        b_trg = n_trg;
        send(127, 7);
        idle(2);
        check("long_err", n_err - b_err, 1);
        check("long_no_trg", n_trg - b_trg, 0);
        send(4, 3);
        idle(1);
        check("after_flush_trg", n_trg - b_trg, 1);

        // Unknown pattern 1100
        b_err = n_err;
        send(12, 4);
        idle(1);
        check("unknown_err", n_err - b_err, 1);

        // Token with pending=2 and a second tin during the wait
        send(4, 3);
        check("tok_pend_before", pending, 2);
        b_terr = n_terr;
        b_rise = n_rise;
        b_hi   = n_hi;
        sp(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) sp(1'b0, i == 2);
        check("tok_pending", pending, 1);
        check("tok_tin_err", n_terr - b_terr, 1);
        check("tok_rises", n_rise - b_rise, 1);
        check("tok_high_clks", n_hi - b_hi, 2);
        check("tok_delay_ns", int'(t_rise - t_acc), D * SYNC_T);

        // sync held low: nothing moves
        b_trg = n_trg;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sync = 1'b0;
            ctr  = 1'b1;
            tin  = 1'b1;
        end
        ctr = 1'b0;
        tin = 1'b0;
        idle(3);
        check("nosync_pending", pending, 1);
        check("nosync_trg", n_trg - b_trg, 0);

        // Saturation: 16 TRGs
        send(44, 6);
        for (int k = 0; k < 16; k++) send(4, 3);
        idle(1);
        check("sat_pending", pending, PMAX);
        check("sat_overflow", overflow, 1);

        // 15 TRGs, then a 16th with a token on its decode edge
        send(44, 6);
        for (int k = 0; k < 15; k++) send(4, 3);
        sp(1'b1, 1'b0);
        sp(1'b0, 1'b0);
        sp(1'b0, 1'b1);
        idle(12);
        check("sat_tok_pending", pending, PMAX);

        // Reset in the middle of a command
        sp(1'b1, 1'b0);
        sp(1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rstcmd_pending", pending, 0);
        check("rstcmd_overflow", overflow, 0);
        check("rstcmd_trg", cmd_trg, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(3);

        // Reset while a token waits
        send(4, 3);
        sp(1'b0, 1'b1);
        idle(3);
        b_rise = n_rise;
        reset = 1'b0;
        #1;
        check("rsttok_tout", tout, 0);
        check("rsttok_pending", pending, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(12);
        check("rsttok_no_tout", n_rise - b_rise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roc_ctr_responder.md
# roc_ctr_responder

Single-ROC emulator for the DTB self-test loop: the far end of the soft TBM's ROC interface. It decodes the serial `roc_ctr` command stream into trigger, calibrate and ROC-reset strobes, and keeps a count of pending triggers. It answers each readout token on `roc_tin` with a `roc_tout` after a fixed delay. It sits between the trigger block's `roc_ctr`/`roc_tin` outputs and its `roc_tout` input when the on-board loopback is selected.

## Interface
- `TOKEN_DELAY`, default 8: sync periods from `tin` sample to `tout` assertion. Range 2..255.
- `PEND_W`, default 4: width of the pending-trigger counter.
- `clk` in 1: 80 MHz system clock.
- `reset` in 1: asynchronous, active-low. Asserted low clears all state.
- `sync` in 1: 40 MHz clock enable. All protocol sampling and state changes occur only on `clk` edges with `sync`=1.
- `ctr` in 1: serial command line. Idle is 0.
- `tin` in 1: token in. Sampled on sync edges.
- `tout` out 1: token out.
- `cmd_trg`, `cmd_cal`, `cmd_rsr` out 1: one-`clk` decode strobes.
- `cmd_err` out 1: one-`clk` strobe for a malformed command.
- `tin_err` out 1: one-`clk` strobe when `tin` is seen while a token is in flight.
- `pending` out PEND_W: number of triggers not yet read out.
- `overflow` out 1: sticky flag, set when a trigger arrives with `pending` saturated.

## Operation
- **Command coding.** MSB first, one bit per sync period.
  - TRG = 100.
  - CAL = 10100.
  - RSR = 101100.
  - A command ends on the first two consecutive 0s after the start bit.
- **Decoder FSM** (bit counter 0..7, 7-bit shift register):
  - IDLE: `ctr`=1 → SHIFT (sr=1, cnt=1).
  - SHIFT: shift in `ctr`, cnt+1.
    - Last two bits 00 → classify by (sr, cnt); go to IDLE.
    - An unknown pattern → `cmd_err`.
    - cnt=7 without a terminator → `cmd_err`, go to FLUSH.
  - FLUSH: wait for two consecutive 0s → IDLE. Set bits in FLUSH never start a command.
- **Pending counter.**
  - Increments on TRG and saturates at 2^PEND_W−1.
  - A TRG at saturation sets `overflow`.
  - Decrements when a token is issued while `pending`>0.
  - TRG and decrement in the same cycle: counter unchanged.
- **RSR** clears `pending`, `overflow` and any token in flight. A `tout` already asserted is dropped on the next sync edge.
- **Token FSM.**
  - States: T_IDLE, T_WAIT (delay counter), T_OUT.
  - T_IDLE: `tin`=1 → T_WAIT, counter=TOKEN_DELAY−1, and `pending` decrements if nonzero. With `pending`=0 the token is passed through with the same delay.
  - T_WAIT: count down to 0 → T_OUT.
  - T_OUT: `tout`=1 for exactly one sync period → T_IDLE.
  - `tin`=1 in T_WAIT or T_OUT: ignored, `tin_err` pulsed.
- **Reset values:** all outputs 0, `pending`=0, both FSMs idle.

## Timing
- `ctr` and `tin` are sampled on the `clk` edge with `sync`=1.
- A decode strobe is high for the single `clk` cycle after the edge that samples the terminating 0. TRG starting at sample n strobes after sample n+2.
- `pending` updates on the same edge as the strobe it follows.
- `tout` rises on the sync edge exactly TOKEN_DELAY sync periods after the `tin` sample. It falls one sync period later.
- With `sync` held 0, nothing advances and strobes stay 0.
- `reset` asserted mid-command or mid-token: immediate clear. No strobe or `tout` is produced for the aborted operation.

## Structure
- **Shared package** `trigger_pkg`:
  - command code constants (TRG/CAL/RSR patterns and lengths)
  - decoder state enum {IDLE, SHIFT, FLUSH}
  - token state enum {T_IDLE, T_WAIT, T_OUT}
- **Sub-module** `ctr_decoder` (decoder FSM plus strobes). The top holds the pending counter and the token FSM.

## Test plan
- **TRG:** `ctr`=1,0,0 on consecutive syncs → one `cmd_trg` pulse; `pending` 0→1. No other strobe.
- **CAL and RSR:** 10100 → `cmd_cal`. Then 101100 after three TRGs → `cmd_rsr`, `pending` 3→0.
- **Malformed:** 1111111 then 00 → one `cmd_err` at the seventh bit. No strobe for the trailing bits; the next 100 decodes as TRG.
- **Token:** TOKEN_DELAY=8, `pending`=2, `tin` pulse → `tout` high 8 sync periods later for 1 sync period; `pending`=1. A second `tin` during the wait → `tin_err`, with no extra `tout`.
- **Saturation:** 16 TRGs with PEND_W=4 → `pending`=15, `overflow`=1. A token during the 16th TRG's decode cycle → `pending` remains 15.
- **Reset:** `reset` driven low mid-command and in T_WAIT → outputs 0 within the same `clk` cycle. No `tout` after release.
